// File: rtl/execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : execute_unit
// Description : Registered LEGv8 execute stage with valid/ready handshakes on
//               both sides. Single-cycle logic/arith/shift ops, an iterative
//               shift-add multiply, NZCV flags and branch-target computation.
// Revision    : 1.0  initial release
// ============================================================================
module execute_unit #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_opa,
  input  logic [WIDTH-1:0] in_opb,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_alusrc,
  input  logic [3:0]       in_func,
  input  logic [WIDTH-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [3:0]       out_flags,
  output logic [WIDTH-1:0] out_branch_target,
  output logic             out_err
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MUL  = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;

  localparam logic [3:0] c_F_AND = 4'b0000;
  localparam logic [3:0] c_F_OR  = 4'b0001;
  localparam logic [3:0] c_F_ADD = 4'b0010;
  localparam logic [3:0] c_F_SUB = 4'b0110;
  localparam logic [3:0] c_F_SLT = 4'b0111;
  localparam logic [3:0] c_F_NOR = 4'b1100;
  localparam logic [3:0] c_F_LSL = 4'b1000;
  localparam logic [3:0] c_F_LSR = 4'b1001;
  localparam logic [3:0] c_F_MUL = 4'b1010;

  // WIDTH is a power of two, so the last iteration index is all ones.
  localparam logic [SHW-1:0] c_CNT_LAST = {SHW{1'b1}};

  logic [1:0]       r_state;
  logic [SHW-1:0]   r_cnt;
  logic             r_mul_fin;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_bt_pend;

  logic             w_accept;
  logic             w_is_mul;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_flags;
  logic             w_zero;
  logic [WIDTH-1:0] w_bt;
  logic [WIDTH-1:0] w_acc_next;

  // Ready is held low during reset so nothing is accepted on the reset edge.
  assign in_ready   = ~rst & ((r_state == c_IDLE) | ((r_state == c_HOLD) & out_ready));
  assign out_valid  = (r_state == c_HOLD);
  assign w_accept   = in_valid & in_ready;
  assign w_is_mul   = MUL_EN && (in_func == c_F_MUL);
  assign w_opb      = in_alusrc ? in_imm : in_opb;
  assign w_bt       = in_pc + (in_imm << 2);
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});

  // Single-cycle datapath: result, error and NZCV for the presented operation.
  always_comb begin
    w_sub   = (in_func == c_F_SUB);
    w_b_eff = w_sub ? ~w_opb : w_opb;
    w_sum   = {1'b0, in_opa} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    w_res   = '0;
    w_err   = 1'b0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    case (in_func)
      c_F_AND: w_res = in_opa & w_opb;
      c_F_OR:  w_res = in_opa | w_opb;
      c_F_ADD, c_F_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (in_opa[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_res[WIDTH-1] != in_opa[WIDTH-1]);
      end
      c_F_SLT: w_res = {{(WIDTH-1){1'b0}}, (in_opa < w_opb)};
      c_F_NOR: w_res = ~(in_opa | w_opb);
      c_F_LSL: w_res = in_opa << w_opb[SHW-1:0];
      c_F_LSR: w_res = in_opa >> w_opb[SHW-1:0];
      // A legal MUL never uses this path; with the multiplier disabled it is illegal.
      c_F_MUL: w_err = ~MUL_EN;
      default: w_err = 1'b1;
    endcase
    w_flags = w_err ? 4'b0000 : {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
    w_zero  = ~w_err && (w_res == '0);
  end

  // Control FSM, multiplier iteration and the registered output bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= c_IDLE;
      r_cnt             <= '0;
      r_mul_fin         <= 1'b0;
      r_mcand           <= '0;
      r_mplier          <= '0;
      r_acc             <= '0;
      r_bt_pend         <= '0;
      out_result        <= '0;
      out_zero          <= 1'b0;
      out_flags         <= 4'b0000;
      out_branch_target <= '0;
      out_err           <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_HOLD: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_mcand   <= in_opa;
              r_mplier  <= w_opb;
              r_acc     <= '0;
              r_cnt     <= '0;
              r_mul_fin <= 1'b0;
              r_bt_pend <= w_bt;
              r_state   <= c_MUL;
            end else begin
              out_result        <= w_res;
              out_zero          <= w_zero;
              out_flags         <= w_flags;
              out_branch_target <= w_bt;
              out_err           <= w_err;
              r_state           <= c_HOLD;
            end
          end else if (r_state == c_HOLD && out_ready) begin
            r_state <= c_IDLE;
          end
        end
        c_MUL: begin
          if (r_mul_fin) begin
            // Outputs change only once the full product is ready.
            out_result        <= r_acc;
            out_zero          <= (r_acc == '0);
            out_flags         <= {r_acc[WIDTH-1], (r_acc == '0), 2'b00};
            out_branch_target <= r_bt_pend;
            out_err           <= 1'b0;
            r_state           <= c_HOLD;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == c_CNT_LAST) begin
              r_mul_fin <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_unit
// Description : Directed self-checking bench for execute_unit (WIDTH=64),
//               with a second instance built with MUL_EN=0.
// Revision    : 1.0  initial release
// ============================================================================
module tb_execute_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_opa;
  logic [63:0] in_opb;
  logic [63:0] in_imm;
  logic        in_alusrc;
  logic [3:0]  in_func;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_zero;
  logic [3:0]  out_flags;
  logic [63:0] out_branch_target;
  logic        out_err;

  logic        nm_in_ready;
  logic        nm_out_valid;
  logic [63:0] nm_out_result;
  logic        nm_out_zero;
  logic [3:0]  nm_out_flags;
  logic [63:0] nm_out_branch_target;
  logic        nm_out_err;

  int total;
  int bad;

  execute_unit #(.WIDTH(64), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opa(in_opa), .in_opb(in_opb), .in_imm(in_imm), .in_alusrc(in_alusrc),
    .in_func(in_func), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_flags(out_flags),
    .out_branch_target(out_branch_target), .out_err(out_err)
  );

  execute_unit #(.WIDTH(64), .MUL_EN(1'b0)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nm_in_ready),
    .in_opa(in_opa), .in_opb(in_opb), .in_imm(in_imm), .in_alusrc(in_alusrc),
    .in_func(in_func), .in_pc(in_pc), .out_valid(nm_out_valid), .out_ready(out_ready),
    .out_result(nm_out_result), .out_zero(nm_out_zero), .out_flags(nm_out_flags),
    .out_branch_target(nm_out_branch_target), .out_err(nm_out_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] imm, input logic src, input logic [63:0] pc);
    in_valid  = 1'b1;
    in_func   = f;
    in_opa    = a;
    in_opb    = b;
    in_imm    = imm;
    in_alusrc = src;
    in_pc     = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_result !== 64'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", out_result); end
    total++; if (out_flags !== 4'h0) begin bad++; $display("FAIL reset_flags got=%h exp=0", out_flags); end
    total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b exp=0", out_zero); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", out_err); end
    total++; if (out_branch_target !== 64'h0) begin bad++; $display("FAIL reset_bt got=%h exp=0", out_branch_target); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add_overflow();
    drive(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b0, 64'h0);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    total++; if (out_result !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL add_result got=%h exp=8000000000000000", out_result); end
    total++; if (out_flags !== 4'b1001) begin bad++; $display("FAIL add_flags got=%b exp=1001", out_flags); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL add_err got=%b exp=0", out_err); end
  endtask

  task automatic test_sub_slt();
    drive(4'b0110, 64'd5, 64'd123, 64'd5, 1'b1, 64'h40);
    tick();
    total++; if (out_result !== 64'h0) begin bad++; $display("FAIL sub_result got=%h exp=0", out_result); end
    total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL sub_zero got=%b exp=1", out_zero); end
    total++; if (out_flags !== 4'b0110) begin bad++; $display("FAIL sub_flags got=%b exp=0110", out_flags); end
    total++; if (out_branch_target !== 64'h54) begin bad++; $display("FAIL sub_bt got=%h exp=54", out_branch_target); end
    drive(4'b0111, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 64'h0);
    tick();
    in_valid = 1'b0;
    total++; if (out_result !== 64'h1) begin bad++; $display("FAIL slt_result got=%h exp=1", out_result); end
    total++; if (out_flags !== 4'b0000) begin bad++; $display("FAIL slt_flags got=%b exp=0000", out_flags); end
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    drive(4'b1010, 64'h1_0000_0001, 64'd3, 64'd2, 1'b0, 64'h200);
    tick();
    in_valid = 1'b0;
    total++; if (nm_out_valid !== 1'b1) begin bad++; $display("FAIL nomul_valid got=%b exp=1", nm_out_valid); end
    total++; if (nm_out_err !== 1'b1) begin bad++; $display("FAIL nomul_err got=%b exp=1", nm_out_err); end
    total++; if (nm_out_result !== 64'h0) begin bad++; $display("FAIL nomul_result got=%h exp=0", nm_out_result); end
    total++; if (nm_out_flags !== 4'h0) begin bad++; $display("FAIL nomul_flags got=%b exp=0000", nm_out_flags); end
    total++; if (nm_out_zero !== 1'b0) begin bad++; $display("FAIL nomul_zero got=%b exp=0", nm_out_zero); end
    for (int i = 0; i < 65; i++) begin
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++; $display("FAIL mul_busy cycle=%0d got ready=%b valid=%b exp ready=0 valid=0", i, in_ready, out_valid);
      end
      tick();
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mul_valid got=%b exp=1", out_valid); end
    total++; if (out_result !== 64'h3_0000_0003) begin bad++; $display("FAIL mul_result got=%h exp=300000003", out_result); end
    total++; if (out_flags !== 4'b0000) begin bad++; $display("FAIL mul_flags got=%b exp=0000", out_flags); end
    total++; if (out_branch_target !== 64'h208) begin bad++; $display("FAIL mul_bt got=%h exp=208", out_branch_target); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  sf  [9];
    logic [63:0] sa  [9];
    logic [63:0] sb  [9];
    logic [63:0] sr  [9];
    logic [3:0]  sfl [9];
    sf[0] = 4'b0000; sa[0] = 64'hF0F0;                sb[0] = 64'h0FF0;                sr[0] = 64'h00F0;                sfl[0] = 4'b0000;
    sf[1] = 4'b0001; sa[1] = 64'hF000;                sb[1] = 64'h000F;                sr[1] = 64'hF00F;                sfl[1] = 4'b0000;
    sf[2] = 4'b0010; sa[2] = 64'hFFFF_FFFF_FFFF_FFFF; sb[2] = 64'h1;                   sr[2] = 64'h0;                   sfl[2] = 4'b0110;
    sf[3] = 4'b0110; sa[3] = 64'd3;                   sb[3] = 64'd5;                   sr[3] = 64'hFFFF_FFFF_FFFF_FFFE; sfl[3] = 4'b1000;
    sf[4] = 4'b1100; sa[4] = 64'h0;                   sb[4] = 64'h0;                   sr[4] = 64'hFFFF_FFFF_FFFF_FFFF; sfl[4] = 4'b1000;
    sf[5] = 4'b1000; sa[5] = 64'h1;                   sb[5] = 64'd67;                  sr[5] = 64'h8;                   sfl[5] = 4'b0000;
    sf[6] = 4'b1001; sa[6] = 64'h8000_0000_0000_0000; sb[6] = 64'd63;                  sr[6] = 64'h1;                   sfl[6] = 4'b0000;
    sf[7] = 4'b0010; sa[7] = 64'h8000_0000_0000_0000; sb[7] = 64'h8000_0000_0000_0000; sr[7] = 64'h0;                   sfl[7] = 4'b0111;
    sf[8] = 4'b0111; sa[8] = 64'd5;                   sb[8] = 64'd3;                   sr[8] = 64'h0;                   sfl[8] = 4'b0100;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(sf[i], sa[i], sb[i], 64'h0, 1'b0, 64'h0);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready op=%0d got=%b exp=1", i, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_result !== sr[i]) begin
        bad++; $display("FAIL stream_result op=%0d got valid=%b res=%h exp valid=1 res=%h", i, out_valid, out_result, sr[i]);
      end
      total++; if (out_flags !== sfl[i]) begin bad++; $display("FAIL stream_flags op=%0d got=%b exp=%b", i, out_flags, sfl[i]); end
    end
    // Stall: a pending op must not be taken and the held result must not move.
    out_ready = 1'b0;
    drive(4'b0010, 64'd10, 64'd20, 64'h0, 1'b0, 64'h0);
    #1;
    for (int i = 0; i < 5; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cycle=%0d got=%b exp=0", i, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_result !== sr[8] || out_flags !== sfl[8]) begin
        bad++; $display("FAIL stall_hold cycle=%0d got valid=%b res=%h flags=%b exp valid=1 res=%h flags=%b",
                        i, out_valid, out_result, out_flags, sr[8], sfl[8]);
      end
    end
    // Drain and accept on the same edge.
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_result !== 64'd30) begin
      bad++; $display("FAIL drain_accept got valid=%b res=%h exp valid=1 res=1e", out_valid, out_result);
    end
  endtask

  task automatic test_illegal();
    drive(4'b0011, 64'd5, 64'd5, 64'h0, 1'b0, 64'h0);
    tick();
    total++; if (out_err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", out_err); end
    total++; if (out_result !== 64'h0 || out_flags !== 4'h0 || out_zero !== 1'b0) begin
      bad++; $display("FAIL illegal_outputs got res=%h flags=%b zero=%b exp res=0 flags=0000 zero=0", out_result, out_flags, out_zero);
    end
    drive(4'b0010, 64'd1, 64'd1, 64'h0, 1'b0, 64'h0);
    tick();
    in_valid = 1'b0;
    total++; if (out_err !== 1'b0 || out_result !== 64'd2) begin
      bad++; $display("FAIL after_illegal got err=%b res=%h exp err=0 res=2", out_err, out_result);
    end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    drive(4'b1010, 64'd7, 64'd9, 64'h0, 1'b0, 64'h0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmul_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmul_ready got=%b exp=1", in_ready); end
    total++; if (out_result !== 64'h0) begin bad++; $display("FAIL rstmul_result got=%h exp=0", out_result); end
    drive(4'b0010, 64'd2, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h100);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_result !== 64'd4) begin
      bad++; $display("FAIL rstmul_add got valid=%b res=%h exp valid=1 res=4", out_valid, out_result);
    end
    total++; if (out_branch_target !== 64'hFC) begin bad++; $display("FAIL rstmul_bt got=%h exp=fc", out_branch_target); end
    tick();
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opa = '0; in_opb = '0; in_imm = '0; in_alusrc = 1'b0; in_func = 4'h0; in_pc = '0;
    test_reset();
    test_add_overflow();
    test_sub_slt();
    test_mul();
    test_back_to_back();
    test_illegal();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
